// File: rtl/dmem_arb.sv
// dmem_arb: core/host arbiter for the single-port data memory.
// The core has priority; a starvation counter forces the host in after
// STARVE_MAX consecutive denied cycles, stalling the core for that one cycle.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arb #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 8,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          stat_clr,
  output logic [15:0]   stat_stall,
  output logic [15:0]   stat_host
);

  typedef enum logic [0:0] {CORE_PRI, HOST_FORCE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_HOST} owner_t;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  owner_t     owner;
  logic [3:0] cnt, cnt_nxt;

  // State and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CORE_PRI;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Owner selection, starvation counting and next-state decision
  always_comb begin
    owner     = OWN_NONE;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CORE_PRI) begin
      if (core_req)      owner = OWN_CORE;
      else if (host_req) owner = OWN_HOST;
    end else begin
      if (host_req)      owner = OWN_HOST;
      else if (core_req) owner = OWN_CORE;
    end
    // A denial is a host request this cycle that did not win the port
    if (!host_req || owner == OWN_HOST) cnt_nxt = 4'd0;
    else if (cnt < CNT_MAX)             cnt_nxt = cnt + 4'd1;
    case (state)
      CORE_PRI:
        if (host_req && owner != OWN_HOST && cnt_nxt == CNT_MAX)
          state_nxt = HOST_FORCE;
      HOST_FORCE:
        if (owner == OWN_HOST || !host_req) state_nxt = CORE_PRI;
      default: state_nxt = CORE_PRI;
    endcase
  end

  // Memory port follows the owner; address/data park on the core when idle
  assign mem_we     = (owner == OWN_CORE) ? core_we :
                      (owner == OWN_HOST) ? host_we : 1'b0;
  assign mem_addr   = (owner == OWN_HOST) ? host_addr  : core_addr;
  assign mem_wdata  = (owner == OWN_HOST) ? host_wdata : core_wdata;
  assign core_rdata = mem_rdata;
  assign core_stall = core_req && (owner != OWN_CORE);
  assign host_gnt   = (owner == OWN_HOST);

  // Registered host read return, valid for one cycle after a granted read
  always_ff @(posedge clk) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_gnt && !host_we;
      if (host_gnt && !host_we) host_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating stall/grant counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_stall <= 16'd0;
      stat_host  <= 16'd0;
    end else begin
      if (core_stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
      if (host_gnt   && stat_host  != 16'hFFFF) stat_host  <= stat_host  + 16'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = stat_clr;
  assign stat_stall   = 16'd0;
  assign stat_host    = 16'd0;
`endif

endmodule
